// File: rtl/rv_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : rv_pkg
// Purpose  : Shared encodings for the RV32I multi-cycle controller and the
//            immediate generator: FSM states, opcodes, mux selects and the
//            packed control word.
// Revision : 1.0 - initial release
// ============================================================================
package rv_pkg;

  // FSM state encoding (3-bit, legacy-compatible constants)
  typedef logic [2:0] state_t;
  localparam state_t ST_FETCH  = 3'd0;
  localparam state_t ST_DECODE = 3'd1;
  localparam state_t ST_EXEC   = 3'd2;
  localparam state_t ST_MEM    = 3'd3;
  localparam state_t ST_WB     = 3'd4;
  localparam state_t ST_TRAP   = 3'd5;

  // Supported major opcodes
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Branch funct3 values handled by this core
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  // PC source select
  localparam logic [1:0] PC_SEL_PLUS4  = 2'd0;
  localparam logic [1:0] PC_SEL_TARGET = 2'd1;

  // Writeback source select
  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_MEM = 2'd1;
  localparam logic [1:0] WB_SEL_PC4 = 2'd2;

  // ALU operation class
  localparam logic [1:0] ALU_OP_ADD   = 2'd0;
  localparam logic [1:0] ALU_OP_SUB   = 2'd1;
  localparam logic [1:0] ALU_OP_FUNCT = 2'd2;

  // Control word driven to the datapath
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic [6:0] imm_ctrl;
    logic       alu_src_b;
    logic [1:0] alu_op;
    logic       reg_we;
    logic [1:0] wb_sel;
  } ctrl_t;

  // True for every opcode the controller can sequence
  function automatic logic op_supported(input logic [6:0] op);
    case (op)
      OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL: return 1'b1;
      default:                                           return 1'b0;
    endcase
  endfunction

  // Only BEQ and BNE are implemented; other branch flavours trap
  function automatic logic branch_f3_ok(input logic [2:0] f3);
    return (f3 == F3_BEQ) || (f3 == F3_BNE);
  endfunction

  // Branch resolution from the ALU compare result
  function automatic logic branch_taken(input logic [2:0] f3, input logic zero);
    return ((f3 == F3_BEQ) && zero) || ((f3 == F3_BNE) && !zero);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rv_ctrl_decode.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : rv_ctrl_decode
// Purpose  : Purely combinational map of (state, opcode, funct3) plus the
//            current-cycle mem_ready / alu_zero qualifiers to the datapath
//            control word.
// Revision : 1.0 - initial release
// ============================================================================
module rv_ctrl_decode
  import rv_pkg::*;
(
  input  state_t     state,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  // Control word for the current state; everything not named stays 0
  always_comb begin
    ctrl = '0;
    case (state)
      ST_FETCH: begin
        ctrl.mem_req = 1'b1;
        if (mem_ready) begin
          ctrl.ir_we  = 1'b1;
          ctrl.pc_we  = 1'b1;
          ctrl.pc_sel = PC_SEL_PLUS4;
        end
      end

      ST_DECODE: begin
        ctrl.imm_ctrl = opcode;
      end

      ST_EXEC: begin
        ctrl.imm_ctrl = opcode;
        case (opcode)
          OP_R: begin
            ctrl.alu_src_b = 1'b0;
            ctrl.alu_op    = ALU_OP_FUNCT;
          end
          OP_IMM: begin
            ctrl.alu_src_b = 1'b1;
            ctrl.alu_op    = ALU_OP_FUNCT;
          end
          OP_LOAD, OP_STORE: begin
            ctrl.alu_src_b = 1'b1;
            ctrl.alu_op    = ALU_OP_ADD;
          end
          OP_BRANCH: begin
            ctrl.alu_op = ALU_OP_SUB;
            // An unsupported funct3 must not redirect the PC on its way to TRAP
            if (branch_f3_ok(funct3) && branch_taken(funct3, alu_zero)) begin
              ctrl.pc_we  = 1'b1;
              ctrl.pc_sel = PC_SEL_TARGET;
            end
          end
          OP_JAL: begin
            ctrl.reg_we = 1'b1;
            ctrl.wb_sel = WB_SEL_PC4;
            ctrl.pc_we  = 1'b1;
            ctrl.pc_sel = PC_SEL_TARGET;
          end
          default: ;
        endcase
      end

      ST_MEM: begin
        ctrl.imm_ctrl     = opcode;
        ctrl.mem_req      = 1'b1;
        ctrl.mem_addr_sel = 1'b1;
        ctrl.mem_we       = (opcode == OP_STORE);
      end

      ST_WB: begin
        ctrl.imm_ctrl = opcode;
        ctrl.reg_we   = 1'b1;
        ctrl.wb_sel   = (opcode == OP_LOAD) ? WB_SEL_MEM : WB_SEL_ALU;
      end

      ST_TRAP: begin
        // Opcode stays visible for debug; every enable and request is off
        ctrl.imm_ctrl = opcode;
      end

      default: ctrl = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/rv_multicycle_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : rv_multicycle_ctrl
// Purpose  : Multi-cycle RV32I control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP)
//            with retired-instruction counter and sticky illegal flag.
// Revision : 1.0 - initial release
// ============================================================================
module rv_multicycle_ctrl
  import rv_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       ir_opcode,
  input  logic [2:0]       ir_funct3,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic [6:0]       imm_ctrl,
  output logic             alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  state_t           state_q,   state_d;
  logic [6:0]       op_q,      op_d;
  logic [2:0]       f3_q,      f3_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  logic             w_retire;
  logic [6:0]       w_opcode;
  logic [2:0]       w_funct3;
  ctrl_t            w_ctrl;

  // In DECODE the IR fields are used live; afterwards the latched copy is used
  assign w_opcode = (state_q == ST_DECODE) ? ir_opcode : op_q;
  assign w_funct3 = (state_q == ST_DECODE) ? ir_funct3 : f3_q;

  rv_ctrl_decode u_decode (
    .state     (state_q),
    .opcode    (w_opcode),
    .funct3    (w_funct3),
    .alu_zero  (alu_zero),
    .mem_ready (mem_ready),
    .ctrl      (w_ctrl)
  );

  // Next-state, IR-field capture and retire detection
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    f3_d     = f3_q;
    w_retire = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (mem_ready) state_d = ST_DECODE;
      end

      ST_DECODE: begin
        op_d    = ir_opcode;
        f3_d    = ir_funct3;
        state_d = op_supported(ir_opcode) ? ST_EXEC : ST_TRAP;
      end

      ST_EXEC: begin
        case (op_q)
          OP_R, OP_IMM:      state_d = ST_WB;
          OP_LOAD, OP_STORE: state_d = ST_MEM;
          OP_BRANCH: begin
            if (branch_f3_ok(f3_q)) begin
              state_d  = ST_FETCH;
              w_retire = 1'b1;
            end else begin
              state_d  = ST_TRAP;
            end
          end
          OP_JAL: begin
            state_d  = ST_FETCH;
            w_retire = 1'b1;
          end
          default: state_d = ST_TRAP;
        endcase
      end

      ST_MEM: begin
        if (mem_ready) begin
          if (op_q == OP_STORE) begin
            state_d  = ST_FETCH;
            w_retire = 1'b1;
          end else begin
            state_d  = ST_WB;
          end
        end
      end

      ST_WB: begin
        state_d  = ST_FETCH;
        w_retire = 1'b1;
      end

      ST_TRAP: state_d = ST_TRAP;

      default: state_d = ST_FETCH;
    endcase
    instret_d = instret_q + {{(CNT_W-1){1'b0}}, w_retire};
  end

  // State, latched IR fields and retire counter; reset aborts any instruction
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      op_q      <= '0;
      f3_q      <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      f3_q      <= f3_d;
      instret_q <= instret_d;
    end
  end

  // Outputs are forced low while reset is held so no request leaks out
  always_comb begin
    mem_req      = rst_n & w_ctrl.mem_req;
    mem_we       = rst_n & w_ctrl.mem_we;
    mem_addr_sel = rst_n & w_ctrl.mem_addr_sel;
    ir_we        = rst_n & w_ctrl.ir_we;
    pc_we        = rst_n & w_ctrl.pc_we;
    pc_sel       = rst_n ? w_ctrl.pc_sel   : 2'd0;
    imm_ctrl     = rst_n ? w_ctrl.imm_ctrl : 7'd0;
    alu_src_b    = rst_n & w_ctrl.alu_src_b;
    alu_op       = rst_n ? w_ctrl.alu_op   : 2'd0;
    reg_we       = rst_n & w_ctrl.reg_we;
    wb_sel       = rst_n ? w_ctrl.wb_sel   : 2'd0;
    illegal      = rst_n & (state_q == ST_TRAP);
    instret      = rst_n ? instret_q : '0;
  end

endmodule
`default_nettype wire
